// File: rtl/banco_registros_rtc_param.sv
// RTC working-register bank: a bus-side req/ack FSM plus a direct user write port.
// The bus-side FSM drives the shared tristate data bus during reads.
// Dirty flags mark user-written slots that the bus has not read yet.
// Optional macro BCD_CHECK_EN rejects writes whose data has a nibble above 9.
module banco_registros_rtc_param #(
   parameter int DATA_W   = 8,
   parameter int NUM_REGS = 12,
   parameter int ADDR_W   = 4,
   parameter int RAM_IDX  = 11,
   parameter int HOLD_CYC = 2
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic [ADDR_W-1:0]          addr,
   input  logic                       rd_req,
   input  logic                       wr_req,
   output logic                       ack,
   output logic                       err,
   inout  wire  [DATA_W-1:0]          dato,
   output logic                       dato_oe,
   input  logic [DATA_W-1:0]          addr_ram,
   input  logic                       usr_we,
   input  logic [ADDR_W-1:0]          usr_addr,
   input  logic [DATA_W-1:0]          usr_wdata,
   output logic [NUM_REGS*DATA_W-1:0] regs_out,
   output logic [NUM_REGS-1:0]        dirty
);

   localparam int CNT_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

   typedef enum logic [1:0] {IDLE, RD_DRV, WR_CAP, DONE} state_t;

   state_t                         state_q, state_d;
   logic [ADDR_W-1:0]              a_q, a_d;
   logic                           rd_q, rd_d;      // current transaction is a read
   logic                           bad_q, bad_d;    // current transaction is rejected
   logic [CNT_W-1:0]               cnt_q, cnt_d;
   logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
   logic [NUM_REGS-1:0]            dirty_q, dirty_d;
   logic                           usr_err_q, usr_err_d;
   logic [DATA_W-1:0]              rd_data;
   logic                           bus_data_ok, usr_data_ok;

   function automatic logic in_range(input logic [ADDR_W-1:0] a);
      return 32'(a) < NUM_REGS;
   endfunction

   // Writable slot: inside the bank and not the read-only RAM-address slot
   function automatic logic writable(input logic [ADDR_W-1:0] a);
      return (32'(a) < NUM_REGS) && (32'(a) != RAM_IDX);
   endfunction

`ifdef BCD_CHECK_EN
   function automatic logic bcd_ok(input logic [DATA_W-1:0] d);
      logic ok;
      ok = 1'b1;
      for (int n = 0; n < DATA_W/4; n++)
         if (d[n*4 +: 4] > 4'd9) ok = 1'b0;
      return ok;
   endfunction
   assign bus_data_ok = bcd_ok(dato);
   assign usr_data_ok = bcd_ok(usr_wdata);
`else
   assign bus_data_ok = 1'b1;
   assign usr_data_ok = 1'b1;
`endif

   // Bus handshake FSM: next state, latched request info and bus outputs
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      rd_d    = rd_q;
      bad_d   = bad_q;
      cnt_d   = cnt_q;
      ack     = 1'b0;
      err     = usr_err_q;
      dato_oe = 1'b0;
      case (state_q)
         IDLE: begin
            if (wr_req) begin
               a_d     = addr;
               rd_d    = 1'b0;
               bad_d   = !writable(addr);
               state_d = WR_CAP;
            end else if (rd_req) begin
               a_d     = addr;
               rd_d    = 1'b1;
               bad_d   = !in_range(addr);
               cnt_d   = '0;
               state_d = RD_DRV;
            end
         end
         RD_DRV: begin
            dato_oe = !bad_q;
            if (cnt_q == CNT_W'(HOLD_CYC-1)) state_d = DONE;
            else cnt_d = cnt_q + 1'b1;
         end
         WR_CAP: begin
            if (!bus_data_ok) bad_d = 1'b1;
            state_d = DONE;
         end
         DONE: begin
            ack     = 1'b1;
            err     = usr_err_q | bad_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Register bank update; user write is applied last so it wins any collision
   always_comb begin
      regs_d    = regs_q;
      dirty_d   = dirty_q;
      usr_err_d = usr_we && writable(usr_addr) && !usr_data_ok;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (state_q == WR_CAP && !bad_q && bus_data_ok && a_q == ADDR_W'(i))
            regs_d[i] = dato;
         if (state_q == DONE && rd_q && !bad_q && a_q == ADDR_W'(i))
            dirty_d[i] = 1'b0;
         if (usr_we && usr_data_ok && usr_addr == ADDR_W'(i) && i != RAM_IDX) begin
            regs_d[i]  = usr_wdata;
            dirty_d[i] = 1'b1;
         end
      end
   end

   // Read mux: RAM-address slot returns the live addr_ram input
   always_comb begin
      rd_data = '0;
      if (32'(a_q) == RAM_IDX) rd_data = addr_ram;
      else
         for (int i = 0; i < NUM_REGS; i++)
            if (a_q == ADDR_W'(i)) rd_data = regs_q[i];
   end

   assign dato     = dato_oe ? rd_data : {DATA_W{1'bz}};
   assign regs_out = regs_q;
   assign dirty    = dirty_q;

   // State and bank registers, asynchronous active-low reset
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         a_q       <= '0;
         rd_q      <= 1'b0;
         bad_q     <= 1'b0;
         cnt_q     <= '0;
         regs_q    <= '0;
         dirty_q   <= '0;
         usr_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         rd_q      <= rd_d;
         bad_q     <= bad_d;
         cnt_q     <= cnt_d;
         regs_q    <= regs_d;
         dirty_q   <= dirty_d;
         usr_err_q <= usr_err_d;
      end
   end

endmodule

// File: doc/banco_registros_rtc_param.md
Name: banco_registros_rtc_param

Overview:
- Parametrised, clocked successor of the RTC working-register multiplexer.
- Holds NUM_REGS time, date and timer registers of DATA_W bits each. One of the addresses is a read-only slot that returns the RAM address input.
- Sits between the RTC bus controller (req/ack handshake, shared bidirectional data bus with explicit output enable) and the user/display logic (direct write port, flat register readout, dirty flags marking values that still need pushing to the RTC).

Parameters:
- DATA_W, 8, width of each register and of the data bus.
- NUM_REGS, 12, number of addressable slots, including the RAM-address slot.
- ADDR_W, 4, address width; must satisfy 2**ADDR_W >= NUM_REGS.
- RAM_IDX, 11, slot index that reads back addr_ram; bus and user writes to it are ignored.
- HOLD_CYC, 2, cycles that dato is driven during a bus read before ack (minimum 1).

Ports:
- clk, input, 1, system clock, rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- addr, input, ADDR_W, bus-side register address; sampled with the request.
- rd_req, input, 1, bus controller requests the value of slot addr.
- wr_req, input, 1, bus controller writes dato into slot addr.
- ack, output, 1, one-cycle completion pulse.
- err, output, 1, one-cycle pulse together with ack on a rejected access.
- dato, inout, DATA_W, shared RTC data bus.
- dato_oe, output, 1, high while this block drives dato.
- addr_ram, input, DATA_W, RAM address value returned at RAM_IDX.
- usr_we, input, 1, user-side write strobe.
- usr_addr, input, ADDR_W, user-side write address.
- usr_wdata, input, DATA_W, user-side write data.
- regs_out, output, NUM_REGS*DATA_W, all slots flattened; slot i occupies bits [i*DATA_W +: DATA_W].
- dirty, output, NUM_REGS, per-slot flag: user-written, not yet read by the bus.

Behaviour:
- Reset (asynchronous, any state, including mid-transaction):
  - All registers, dirty, ack, err and dato_oe go to 0; the FSM goes to IDLE.
  - dato is released to high-Z.
- Bus tristate rule: dato is driven only when dato_oe=1; otherwise it is all Z.
- FSM states: IDLE, RD_DRV, WR_CAP, DONE.
- IDLE:
  - A request latches addr into a_q.
  - wr_req goes to WR_CAP. wr_req takes priority if both requests are high; rd_req is then ignored, not queued.
  - rd_req alone goes to RD_DRV.
  - Requests are not accepted in any other state.
- RD_DRV:
  - dato_oe=1. dato carries slot[a_q], or addr_ram when a_q==RAM_IDX.
  - Stays HOLD_CYC cycles, then goes to DONE.
- WR_CAP (one cycle): dato is sampled on the clock edge leaving this state into slot[a_q], then DONE.
- DONE (one cycle): ack=1, dato_oe=0, then IDLE.
  - Latency from the request edge to ack: read HOLD_CYC+1 cycles; write 2 cycles.
  - The requester holds the request until ack. A request still high in the cycle after DONE starts a new transaction.
- Out-of-range address (a_q >= NUM_REGS):
  - Read: dato_oe stays 0.
  - Write: no register changes.
  - Both go through DONE with ack=1 and err=1.
- Bus write to RAM_IDX: ignored, err=1.
- User port:
  - usr_we with usr_addr < NUM_REGS and != RAM_IDX writes usr_wdata on the clock edge and sets dirty[usr_addr].
  - Other usr_we writes are ignored silently.
- Bus read clears dirty[a_q] at the DONE edge.
- Collision, same slot, same edge:
  - usr_we together with the bus write capture (WR_CAP edge): the user write wins and dirty is set.
  - usr_we together with the read dirty-clear (DONE edge): the user data is stored and dirty stays 1.
- regs_out is registered state: it reflects writes one cycle after the write edge.

Optional Feature:
- Macro: BCD_CHECK_EN.
- Defined:
  - Bus and user writes are rejected if any 4-bit nibble of the data is > 9 (register unchanged, dirty unchanged).
  - A rejected bus write gives ack with err=1.
  - A rejected user write raises err for one cycle, without ack.
- Undefined: any value is accepted; err arises only from address faults.

Test Plan:
- Reset then bus read of slot 0 with HOLD_CYC=2 -> dato_oe high 2 cycles with dato=8'h00; ack at cycle 3; err=0; dato Z afterwards.
- usr_we addr 2 data 8'h23 -> regs_out slot2=8'h23, dirty[2]=1; then bus read addr 2 -> dato=8'h23, dirty[2]=0 after ack.
- Bus write addr 4 with dato=8'h15 driven externally -> ack 2 cycles after the request; slot4=8'h15; dirty[4] unchanged.
- Read addr 11 with addr_ram=8'hA7 -> dato=8'hA7; write to addr 11 -> ack with err=1, no change; read addr 13 -> ack with err=1, dato_oe never high.
- rd_req and wr_req together, with usr_we to the same slot on the WR_CAP edge -> user data stored, dirty=1; assert reset_n low mid-RD_DRV -> dato_oe=0 immediately, all regs 0.
- BCD_CHECK_EN defined: bus write 8'h1A -> ack and err, register unchanged; user write 8'h59 accepted.
